// File: rtl/hop_pkg.sv
// Shared definitions for the hop-selection blocks.
//   hop_state_e      : sequencer states of hop_select_seq
//   HOP_NUM_CH_DEF   : default number of RF channels
//   HOP_MIN_USED_DEF : default minimum used-channel count for AFH
//   basic_map()      : basic-hop position -> physical channel (evens first, then odds)
package hop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KERN  = 3'd1,
        ST_CHK   = 3'd2,
        ST_CNT   = 3'd3,
        ST_MODN  = 3'd4,
        ST_REMAP = 3'd5,
        ST_DONE  = 3'd6
    } hop_state_e;

    localparam int HOP_NUM_CH_DEF   = 79;
    localparam int HOP_MIN_USED_DEF = 20;

    // Positions below ceil(num_ch/2) land on even channels, the rest on odd ones.
    function automatic int basic_map(input int p, input int num_ch);
        int h;
        int r;
        h = (num_ch + 32'sd1) / 32'sd2;
        if (p < h) begin
            r = 32'sd2 * p;
        end else begin
            r = 32'sd2 * (p - h) + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hop_select_seq_perm5.sv
// hop_perm5: 7-stage, 14-bit-controlled butterfly permutation of a 5-bit word.
//   z  : word to permute
//   p  : control word; p[13] drives the first butterfly, p[0] the last
//   zp : permuted word
module hop_perm5 (
    input  logic [4:0]  z,
    input  logic [13:0] p,
    output logic [4:0]  zp
);

    // Conditionally exchange bits i and j of v.
    function automatic logic [4:0] swap2(input logic [4:0] v, input logic [2:0] i,
                                         input logic [2:0] j, input logic en);
        logic [4:0] r;
        r = v;
        if (en) begin
            r[i] = v[j];
            r[j] = v[i];
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [4:0] t_s;

    // Butterfly network; the two swaps in each stage touch disjoint bits.
    always_comb begin
        t_s = z;
        t_s = swap2(t_s, 3'd1, 3'd2, p[13]);
        t_s = swap2(t_s, 3'd0, 3'd3, p[12]);
        t_s = swap2(t_s, 3'd1, 3'd3, p[11]);
        t_s = swap2(t_s, 3'd2, 3'd4, p[10]);
        t_s = swap2(t_s, 3'd0, 3'd3, p[9]);
        t_s = swap2(t_s, 3'd1, 3'd4, p[8]);
        t_s = swap2(t_s, 3'd3, 3'd4, p[7]);
        t_s = swap2(t_s, 3'd0, 3'd2, p[6]);
        t_s = swap2(t_s, 3'd1, 3'd3, p[5]);
        t_s = swap2(t_s, 3'd0, 3'd4, p[4]);
        t_s = swap2(t_s, 3'd3, 3'd4, p[3]);
        t_s = swap2(t_s, 3'd1, 3'd2, p[2]);
        t_s = swap2(t_s, 3'd2, 3'd3, p[1]);
        t_s = swap2(t_s, 3'd0, 3'd1, p[0]);
        zp  = t_s;
    end

endmodule

// File: rtl/hop_select_seq.sv
// hop_select_seq: sequential hop-channel selector with run-time AFH remap.
// Computes the basic-hop channel; when AFH is enabled and that channel is unused,
// counts the used channels N, reduces s mod N by repeated subtraction and walks
// the basic map to the k'-th used channel.
// Optional build macro HOP_NCACHE_EN: caches the last successfully counted map and
// its N so an unchanged map skips the counting pass (results identical, lower latency).
// Ports:
//   clk, rst (async, active high), start (1-cycle request, inputs sampled with it)
//   X, A, C, B, D, Y1, Y2, E, F, Fprime : hop kernel inputs
//   afh_en, chan_map                    : AFH enable and used-channel map
//   busy, done, fk, used_n, map_err     : status and result (all registered)
module hop_select_seq
    import hop_pkg::*;
#(
    parameter int NUM_CH   = HOP_NUM_CH_DEF,
    parameter int CH_W     = 7,
    parameter int MIN_USED = HOP_MIN_USED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        X,
    input  logic [4:0]        A,
    input  logic [4:0]        C,
    input  logic [3:0]        B,
    input  logic [8:0]        D,
    input  logic              Y1,
    input  logic [5:0]        Y2,
    input  logic [CH_W-1:0]   E,
    input  logic [CH_W-1:0]   F,
    input  logic [CH_W-1:0]   Fprime,
    input  logic              afh_en,
    input  logic [NUM_CH-1:0] chan_map,
    output logic              busy,
    output logic              done,
    output logic [CH_W-1:0]   fk,
    output logic [CH_W:0]     used_n,
    output logic              map_err
);

    // Sum width that holds two CH_W terms plus the 5-bit and 6-bit terms.
    localparam int SUM_W = ((CH_W > 7) ? CH_W : 7) + 2;
    localparam int NW    = CH_W + 1;
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   MIN_N    = NW'(MIN_USED);

    // Read bit i of a channel map without a width-mismatched index.
    function automatic logic map_bit(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] i);
        logic [NUM_CH-1:0] t;
        t = m >> i;
        return t[0];
    endfunction

    hop_state_e        state_r;
    logic [4:0]        z_r;
    logic [13:0]       p_r;
    logic [CH_W-1:0]   e_r;
    logic [CH_W-1:0]   f_r;
    logic [CH_W-1:0]   fp_r;
    logic [5:0]        y2_r;
    logic              afh_r;
    logic [NUM_CH-1:0] map_r;
    logic [CH_W-1:0]   k_r;
    logic [SUM_W-1:0]  s_r;
    logic [CH_W-1:0]   idx_r;
    logic [CH_W:0]     acc_r;

`ifdef HOP_NCACHE_EN
    logic              cache_vld_r;
    logic [NUM_CH-1:0] cache_map_r;
    logic [CH_W:0]     cache_n_r;
`endif

    logic [4:0]        zsum_s;
    logic [4:0]        z_in_s;
    logic [13:0]       p_in_s;
    logic [4:0]        zp_s;
    logic [SUM_W-1:0]  sum_k_s;
    logic [SUM_W-1:0]  sum_s_s;
    logic [CH_W-1:0]   k_mod_s;
    logic [CH_W-1:0]   basic_k_s;
    logic [CH_W-1:0]   basic_p_s;
    logic              k_used_s;
    logic              p_used_s;
    logic              cnt_bit_s;
    logic [CH_W:0]     acc_next_s;
    logic [SUM_W-1:0]  n_ext_s;
    logic [SUM_W-1:0]  acc_ext_s;

    hop_perm5 u_perm (
        .z  (z_r),
        .p  (p_r),
        .zp (zp_s)
    );

    // Input pre-processing, kernel sums and map lookups.
    always_comb begin
        zsum_s     = X + A;
        z_in_s     = {zsum_s[4], zsum_s[3:0] ^ B};
        p_in_s     = {C ^ {5{Y1}}, D};
        sum_k_s    = SUM_W'(e_r) + SUM_W'(f_r) + SUM_W'(zp_s) + SUM_W'(y2_r);
        sum_s_s    = SUM_W'(e_r) + SUM_W'(fp_r) + SUM_W'(zp_s) + SUM_W'(y2_r);
        k_mod_s    = CH_W'(sum_k_s % SUM_W'(NUM_CH));
        basic_k_s  = CH_W'(basic_map(int'(k_r), NUM_CH));
        basic_p_s  = CH_W'(basic_map(int'(idx_r), NUM_CH));
        k_used_s   = map_bit(map_r, basic_k_s);
        p_used_s   = map_bit(map_r, basic_p_s);
        cnt_bit_s  = map_bit(map_r, idx_r);
        acc_next_s = acc_r + NW'(cnt_bit_s);
        n_ext_s    = SUM_W'(used_n);
        acc_ext_s  = SUM_W'(acc_r);
    end

    // Sequencer: latches the request, runs kernel / count / mod-N / remap, drives outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            fk      <= '0;
            used_n  <= '0;
            map_err <= 1'b0;
            z_r     <= '0;
            p_r     <= '0;
            e_r     <= '0;
            f_r     <= '0;
            fp_r    <= '0;
            y2_r    <= '0;
            afh_r   <= 1'b0;
            map_r   <= '0;
            k_r     <= '0;
            s_r     <= '0;
            idx_r   <= '0;
            acc_r   <= '0;
`ifdef HOP_NCACHE_EN
            cache_vld_r <= 1'b0;
            cache_map_r <= '0;
            cache_n_r   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                // DONE also accepts a new request: busy is already low there.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        z_r     <= z_in_s;
                        p_r     <= p_in_s;
                        e_r     <= E;
                        f_r     <= F;
                        fp_r    <= Fprime;
                        y2_r    <= Y2;
                        afh_r   <= afh_en;
                        map_r   <= chan_map;
                        map_err <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_KERN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_KERN: begin
                    k_r     <= k_mod_s;
                    s_r     <= sum_s_s;
                    state_r <= ST_CHK;
                end
                ST_CHK: begin
                    if (!afh_r || k_used_s) begin
                        fk      <= basic_k_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
`ifdef HOP_NCACHE_EN
                        if (cache_vld_r && (cache_map_r == map_r)) begin
                            used_n  <= cache_n_r;
                            state_r <= ST_MODN;
                        end else begin
                            idx_r   <= '0;
                            acc_r   <= '0;
                            state_r <= ST_CNT;
                        end
`else
                        idx_r   <= '0;
                        acc_r   <= '0;
                        state_r <= ST_CNT;
`endif
                    end
                end
                ST_CNT: begin
                    acc_r <= acc_next_s;
                    if (idx_r == LAST_IDX) begin
                        used_n <= acc_next_s;
                        idx_r  <= '0;
                        // Too few channels (including N = 0): fall back to the basic hop.
                        if (acc_next_s < MIN_N) begin
                            fk      <= basic_k_s;
                            map_err <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
`ifdef HOP_NCACHE_EN
                            cache_vld_r <= 1'b1;
                            cache_map_r <= map_r;
                            cache_n_r   <= acc_next_s;
`endif
                            state_r <= ST_MODN;
                        end
                    end else begin
                        idx_r <= idx_r + CH_W'(1);
                    end
                end
                ST_MODN: begin
                    // Zero guard keeps the loop finite even if N were ever 0.
                    if ((used_n != '0) && (s_r >= n_ext_s)) begin
                        s_r <= s_r - n_ext_s;
                    end else begin
                        idx_r   <= '0;
                        acc_r   <= '0;
                        state_r <= ST_REMAP;
                    end
                end
                ST_REMAP: begin
                    // acc_r counts used channels already passed; s_r now holds k'.
                    if (p_used_s && (acc_ext_s == s_r)) begin
                        fk      <= basic_p_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        if (p_used_s) begin
                            acc_r <= acc_r + NW'(1);
                        end else begin
                            acc_r <= acc_r;
                        end
                        if (idx_r == LAST_IDX) begin
                            // Unreachable while k' < N; fail safe to the basic hop.
                            fk      <= basic_k_s;
                            map_err <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r <= idx_r + CH_W'(1);
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hop_select_seq.sv
// Self-checking bench for hop_select_seq: directed vectors plus randomized
// requests checked against a behavioural model of the hop rules.
module tb_hop_select_seq;

    localparam int NUM_CH   = 79;
    localparam int CH_W     = 7;
    localparam int MIN_USED = 20;
    localparam int AFH_MAX_LAT = 3 + NUM_CH + 18 + NUM_CH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [4:0]        X, A, C;
    logic [3:0]        B;
    logic [8:0]        D;
    logic              Y1;
    logic [5:0]        Y2;
    logic [CH_W-1:0]   E, F, Fprime;
    logic              afh_en;
    logic [NUM_CH-1:0] chan_map;
    logic              busy, done, map_err;
    logic [CH_W-1:0]   fk;
    logic [CH_W:0]     used_n;

    int n_pass = 0;
    int n_total = 0;
    int exp_used_n = 0;

    hop_select_seq #(.NUM_CH(NUM_CH), .CH_W(CH_W), .MIN_USED(MIN_USED)) dut (
        .clk(clk), .rst(rst), .start(start), .X(X), .A(A), .C(C), .B(B), .D(D),
        .Y1(Y1), .Y2(Y2), .E(E), .F(F), .Fprime(Fprime), .afh_en(afh_en),
        .chan_map(chan_map), .busy(busy), .done(done), .fk(fk), .used_n(used_n),
        .map_err(map_err)
    );

    always #5 clk = ~clk;

    function automatic int bmap(input int p);
        return (p < (NUM_CH + 1) / 2) ? 2 * p : 2 * (p - (NUM_CH + 1) / 2) + 1;
    endfunction

    // Behavioural model: kernel arithmetic, then optional AFH remap via a used-channel list.
    function automatic void ref_hop(input int x, a, c, b, d, y1, y2, e, f, fp,
                                    input bit afh, input logic [NUM_CH-1:0] m,
                                    inout int n_io, output int fk_o, output bit err_o,
                                    output bit afh_path);
        int pa[14];
        int pb[14];
        int zq, z, p, k, n, kp;
        int q[$];
        pa = '{0, 2, 1, 3, 0, 1, 0, 3, 1, 0, 2, 1, 0, 1};
        pb = '{1, 3, 2, 4, 4, 3, 2, 4, 4, 3, 4, 3, 3, 2};
        zq = (x + a) % 32;
        z  = (zq & 16) | ((zq & 15) ^ b);
        p  = (((c ^ (y1 != 0 ? 31 : 0)) & 31) << 9) | (d & 511);
        for (int i = 13; i >= 0; i--) begin
            if (((p >> i) & 1) == 1 && (((z >> pa[i]) & 1) != ((z >> pb[i]) & 1)))
                z = z ^ ((1 << pa[i]) | (1 << pb[i]));
        end
        k = (e + f + z + y2) % NUM_CH;
        err_o = 1'b0;
        afh_path = 1'b0;
        if (!afh || m[bmap(k)]) begin
            fk_o = bmap(k);
        end else begin
            afh_path = 1'b1;
            n = $countones(m);
            n_io = n;
            if (n < MIN_USED) begin
                fk_o = bmap(k);
                err_o = 1'b1;
            end else begin
                kp = (e + fp + z + y2) % n;
                for (int i = 0; i < NUM_CH; i++) if (m[bmap(i)]) q.push_back(bmap(i));
                fk_o = q[kp];
            end
        end
    endfunction

    task automatic set_zero();
        X = 5'd0; A = 5'd0; C = 5'd0; B = 4'd0; D = 9'd0; Y1 = 1'b0; Y2 = 6'd0;
        E = 7'd0; F = 7'd0; Fprime = 7'd0; afh_en = 1'b0; chan_map = '0;
    endtask

    task automatic set_map_low(input int nbits);
        chan_map = '0;
        for (int i = 0; i < nbits; i++) chan_map[i] = 1'b1;
    endtask

    task automatic scramble();
        X = 5'($urandom_range(0, 31)); A = 5'($urandom_range(0, 31));
        C = 5'($urandom_range(0, 31)); B = 4'($urandom_range(0, 15));
        D = 9'($urandom_range(0, 511)); Y1 = 1'($urandom_range(0, 1));
        Y2 = 6'($urandom_range(0, 63)); E = 7'($urandom_range(0, 127));
        F = 7'($urandom_range(0, 127)); Fprime = 7'($urandom_range(0, 127));
        afh_en = 1'($urandom_range(0, 1));
        for (int i = 0; i < NUM_CH; i++) chan_map[i] = 1'($urandom_range(0, 1));
    endtask

    // Pulse start and wait (bounded) for done; lat counts cycles from start to done.
    task automatic run_op(input bit scr, output int lat);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; lat = 1;
        while (done !== 1'b1 && lat < 400) begin
            if (scr) scramble();
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        set_zero(); rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
        n_total++; if (fk !== 7'd0) $display("FAIL reset_fk: got %0d want 0", fk); else n_pass++;
        n_total++; if (used_n !== 8'd0) $display("FAIL reset_used_n: got %0d want 0", used_n); else n_pass++;
        n_total++; if (map_err !== 1'b0) $display("FAIL reset_map_err: got %0b want 0", map_err); else n_pass++;
        rst = 1'b0; exp_used_n = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        set_zero();
        run_op(1'b0, lat);
        n_total++; if (lat !== 3 || done !== 1'b1) $display("FAIL basic_latency: got %0d done=%0b want 3", lat, done); else n_pass++;
        n_total++; if (fk !== 7'd0) $display("FAIL basic_zero_fk: got %0d want 0", fk); else n_pass++;
        n_total++; if (map_err !== 1'b0) $display("FAIL basic_zero_err: got %0b want 0", map_err); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_pulse: done=%0b busy=%0b want 0/0", done, busy); else n_pass++;
        E = 7'd40;
        run_op(1'b0, lat);
        n_total++; if (fk !== 7'd1) $display("FAIL basic_e40: got %0d want 1", fk); else n_pass++;
        E = 7'd78; F = 7'd5;
        run_op(1'b0, lat);
        n_total++; if (fk !== 7'd8) $display("FAIL basic_e78_f5: got %0d want 8", fk); else n_pass++;
    endtask

    task automatic test_abort();
        int ndone = 0;
        set_zero(); set_map_low(20); afh_en = 1'b1; E = 7'd60; Fprime = 7'd12;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (99) @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %0b want 1", busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || fk !== 7'd0)
            $display("FAIL abort_reset: busy=%0b done=%0b fk=%0d want 0/0/0", busy, done, fk); else n_pass++;
        @(negedge clk); rst = 1'b0; exp_used_n = 0;
        repeat (200) begin @(negedge clk); if (done === 1'b1) ndone++; end
        n_total++; if (ndone !== 0) $display("FAIL abort_no_done: got %0d want 0", ndone); else n_pass++;
    endtask

    task automatic test_afh();
        int lat;
        set_zero(); set_map_low(20); afh_en = 1'b1; E = 7'd60; Fprime = 7'd3;
        run_op(1'b0, lat);
        n_total++; if (fk !== 7'd6) $display("FAIL afh_fp3_fk: got %0d want 6", fk); else n_pass++;
        n_total++; if (used_n !== 8'd20) $display("FAIL afh_fp3_n: got %0d want 20", used_n); else n_pass++;
        n_total++; if (map_err !== 1'b0) $display("FAIL afh_fp3_err: got %0b want 0", map_err); else n_pass++;
        n_total++; if (lat > AFH_MAX_LAT) $display("FAIL afh_latency: got %0d want <= %0d", lat, AFH_MAX_LAT); else n_pass++;
        Fprime = 7'd12;
        run_op(1'b0, lat);
        n_total++; if (fk !== 7'd5) $display("FAIL afh_fp12_fk: got %0d want 5", fk); else n_pass++;
        exp_used_n = 20;
    endtask

    task automatic test_map_err();
        int lat;
        set_zero(); set_map_low(10); afh_en = 1'b1; E = 7'd60;
        run_op(1'b0, lat);
        n_total++; if (map_err !== 1'b1) $display("FAIL maperr_flag: got %0b want 1", map_err); else n_pass++;
        n_total++; if (fk !== 7'd41) $display("FAIL maperr_fk: got %0d want 41", fk); else n_pass++;
        n_total++; if (used_n !== 8'd10) $display("FAIL maperr_n: got %0d want 10", used_n); else n_pass++;
        exp_used_n = 10;
        set_zero();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_total++; if (map_err !== 1'b0 || busy !== 1'b1) $display("FAIL maperr_clear: err=%0b busy=%0b want 0/1", map_err, busy); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_busy_start();
        int ndone = 0;
        set_zero(); set_map_low(20); afh_en = 1'b1; E = 7'd60; Fprime = 7'd3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        E = 7'd40; afh_en = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) begin @(negedge clk); if (done === 1'b1) ndone++; end
        n_total++; if (ndone !== 1) $display("FAIL busy_start_dones: got %0d want 1", ndone); else n_pass++;
        n_total++; if (fk !== 7'd6) $display("FAIL busy_start_fk: got %0d want 6", fk); else n_pass++;
        exp_used_n = 20;
    endtask

    task automatic test_cache();
        int lat0, lat1, lat2, want;
        set_zero(); set_map_low(30); afh_en = 1'b1; E = 7'd60; Fprime = 7'd3;
        run_op(1'b0, lat0);
        set_map_low(20);
        run_op(1'b0, lat1);
        n_total++; if (fk !== 7'd6) $display("FAIL cache_run1_fk: got %0d want 6", fk); else n_pass++;
        run_op(1'b0, lat2);
        n_total++; if (fk !== 7'd6 || used_n !== 8'd20) $display("FAIL cache_run2: fk=%0d n=%0d want 6/20", fk, used_n); else n_pass++;
`ifdef HOP_NCACHE_EN
        want = lat1 - NUM_CH;
`else
        want = lat1;
`endif
        n_total++; if (lat2 !== want) $display("FAIL cache_latency: got %0d want %0d", lat2, want); else n_pass++;
        exp_used_n = 20;
    endtask

    task automatic test_random();
        int lat, efk, n_before;
        bit eerr, apath;
        for (int it = 0; it < 60; it++) begin
            scramble();
            case (it % 3)
                0: for (int i = 0; i < NUM_CH; i++) chan_map[i] = ($urandom_range(0, 99) < 15);
                1: for (int i = 0; i < NUM_CH; i++) chan_map[i] = ($urandom_range(0, 99) < 45);
                default: ;
            endcase
            n_before = exp_used_n;
            ref_hop(int'(X), int'(A), int'(C), int'(B), int'(D), int'(Y1), int'(Y2), int'(E),
                    int'(F), int'(Fprime), afh_en, chan_map, exp_used_n, efk, eerr, apath);
            run_op(1'b1, lat);
            n_total++;
            if (done !== 1'b1 || fk !== CH_W'(efk) || map_err !== eerr || used_n !== 8'(exp_used_n))
                $display("FAIL random_%0d: fk=%0d err=%0b n=%0d done=%0b want fk=%0d err=%0b n=%0d (prev n %0d)",
                         it, fk, map_err, used_n, done, efk, eerr, exp_used_n, n_before);
            else n_pass++;
            n_total++;
            if ((!apath && lat !== 3) || (apath && lat > AFH_MAX_LAT))
                $display("FAIL random_lat_%0d: got %0d want %0s", it, lat, apath ? "<=179" : "3");
            else n_pass++;
        end
    endtask

    initial begin
        set_zero();
        test_reset();
        test_basic();
        test_abort();
        test_afh();
        test_map_err();
        test_busy_start();
        test_cache();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hop_select_seq.md
Name: hop_select_seq

Overview:
- Parametrised, sequential successor of the Core 5.1 §2.6.2 hopping kernel.
- Computes the basic-hop channel index. When AFH is enabled and that channel is unused, it builds the used-channel count N and performs the mod-N remap by scanning the channel map at run time, instead of using a fixed remap table.
- Sits between the clock/address-derived hop inputs and the RF channel register. Uses a start/done handshake so the multi-cycle remap cannot stall the slot timing logic.

Parameters:
- NUM_CH, 79, number of RF channels (basic-hop modulus); must be ≥ 2.
- CH_W, 7, width of channel indices; 2**CH_W ≥ NUM_CH.
- MIN_USED, 20, minimum used-channel count accepted for AFH.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle request; inputs are sampled in the same cycle.
- X  in  5  hop input X.
- A  in  5  hop input A.
- C  in  5  hop input C.
- B  in  4  XOR operand.
- D  in  9  permutation control, low bits.
- Y1  in  1  inverts C in the permutation control.
- Y2  in  6  adder term.
- E  in  CH_W  adder term.
- F  in  CH_W  basic-hop adder term.
- Fprime  in  CH_W  AFH adder term.
- afh_en  in  1  enables the AFH remap.
- chan_map  in  NUM_CH  used-channel map; bit i = physical channel i is used.
- busy  out  1  high from the cycle after start until done.
- done  out  1  1-cycle pulse; fk is valid.
- fk  out  CH_W  physical channel; held until the next done.
- used_n  out  CH_W+1  last computed N.
- map_err  out  1  set with done when N < MIN_USED; cleared at the next start.

Behaviour:
- Reset: busy=0, done=0, fk=0, used_n=0, map_err=0, state=IDLE.
- Reset mid-operation aborts the operation with no done pulse.
- start while busy is ignored.
- All inputs, including chan_map, are latched on start. Later input changes have no effect on the current operation.
- Kernel arithmetic:
  - Z' = (X+A) mod 32.
  - Z[3:0] = Z'[3:0]^B; Z[4] = Z'[4].
  - P = {C^{5{Y1}}, D}.
  - Apply the 7-stage butterfly to Z under P: stage pairs (1,2)/(0,3) on P13/P12; (1,3)/(2,4) on P11/P10; (0,3)/(1,4) on P9/P8; (3,4)/(0,2) on P7/P6; (1,3)/(0,4) on P5/P4; (3,4)/(1,2) on P3/P2; (2,3)/(0,1) on P1/P0. Result is Zp.
  - k = (E+F+Zp+Y2) mod NUM_CH. Use full-width sums, no truncation.
- Basic map: H = ceil(NUM_CH/2). Position p maps to physical channel 2p if p < H, otherwise 2(p−H)+1.
- FSM:
  - IDLE: on start, latch inputs → KERN.
  - KERN: register Zp and k → CHK.
  - CHK:
    - If !afh_en or chan_map[basic(k)]: fk=basic(k), done next cycle → DONE.
    - Otherwise → CNT.
  - CNT: one map bit per cycle, NUM_CH cycles, accumulating N.
    - If N < MIN_USED: fk=basic(k), map_err=1 → DONE.
    - Otherwise: s = E+Fprime+Zp+Y2 → MODN.
  - MODN: subtract N from s once per cycle while s ≥ N. The result is k'.
  - REMAP: walk positions p = 0..NUM_CH−1, one per cycle, counting used basic(p). When the count reaches k', fk=basic(p) → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Latency from start to done:
  - Basic path: 3 cycles.
  - AFH path: ≤ 3 + NUM_CH + ceil(s_max/MIN_USED) + NUM_CH cycles.
- N = 0 is never used as a divisor; it is caught by the MIN_USED check.

Optional Feature:
- Macro HOP_NCACHE_EN.
- When defined:
  - Keep a registered copy of the last counted chan_map and its N.
  - In CHK, if the latched map equals the copy and a previous count is valid, skip CNT and go directly to MODN.
  - Reset invalidates the cache.
- When undefined: CNT always runs. Functional results are identical either way; only latency differs.

Decomposition:
- Package hop_pkg holds:
  - the FSM state enum;
  - default NUM_CH / MIN_USED constants;
  - function basic_map(p, NUM_CH).
- One combinational sub-module, hop_perm5, implements the 14-bit-controlled butterfly; it is reused by later hop blocks.

Test Plan:
- All inputs 0, afh_en=0, start → done exactly 3 cycles later, fk=0, map_err=0.
- E=40, others 0, afh_en=0 → fk=1. E=78, F=5 → k=4, fk=8.
- afh_en=1, chan_map with bits 0..19 set (N=20), E=60, Fprime=3, others 0 → basic channel 41 unused, k'=3, fk=6, used_n=20. Same with Fprime=12 → k'=12, fk=5.
- afh_en=1, only bits 0..9 set, E=60 → map_err=1, fk=41, used_n=10.
- Reset asserted during REMAP → busy/done/fk drop to 0 immediately. A start pulsed while busy produces no second done.
- HOP_NCACHE_EN: repeat the third scenario twice with the same map → second run completes NUM_CH cycles sooner with identical fk.
